// File: rtl/cordic_result_packer.sv
// cordic_result_packer
// Converts the CORDIC core's signed Q2.FRAC_BITS sine/cosine pair back to
// IEEE-754 single precision. The quarter-turn folding applied by the angle
// front end is undone first. Each channel is then normalised, rounded to
// nearest with ties to even, and packed.
// Optional build macro: CLAMP_UNIT_EN. When it is defined, any magnitude
// above 1.0 is forced to exactly +/-1.0 to absorb CORDIC gain overshoot.
module cordic_result_packer #(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = WIDTH - 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] sin_in,
    input  logic [WIDTH-1:0] cos_in,
    input  logic [2:0]       flips,
    output logic [31:0]      sin_out,
    output logic [31:0]      cos_out,
    output logic             done,
    output logic             ready
);

    // One extra bit so that negating -2.0 stays representable.
    localparam int MW = WIDTH + 1;
    localparam logic [MW-1:0] ONE_MAG = {{(MW-1){1'b0}}, 1'b1} << FRAC_BITS;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ROTATE = 3'd1,
        MAG    = 3'd2,
        NORM   = 3'd3,
        PACK   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0]     sin_cap_reg, cos_cap_reg;
    logic [2:0]           flips_reg;
    logic signed [MW-1:0] rot_reg  [2];   // index 0 = sine, 1 = cosine
    logic [1:0]           sign_reg;
    logic [MW-1:0]        mag_reg  [2];
    logic [MW-1:0]        norm_reg [2];
    logic [7:0]           exp_reg  [2];
    logic [31:0]          sin_out_reg, cos_out_reg;
    logic                 done_reg;

    logic accept;

    // Still busy during the done cycle; the next request is taken one edge later.
    assign ready  = (state_reg == IDLE) && !done_reg;
    assign accept = valid_in && ready;

    // ------------------------------------------------------------------
    // Quadrant unfolding: rotate by k = (-flips) mod 4 quarter turns.
    // ------------------------------------------------------------------
    logic signed [MW-1:0] sin_ext, cos_ext, rot_s, rot_c;
    logic [2:0]           neg_flips;
    logic [1:0]           quad;
    logic                 unused_flip_msb;

    assign sin_ext         = {sin_cap_reg[WIDTH-1], sin_cap_reg};
    assign cos_ext         = {cos_cap_reg[WIDTH-1], cos_cap_reg};
    assign neg_flips       = 3'd0 - flips_reg;
    assign quad            = neg_flips[1:0];
    assign unused_flip_msb = neg_flips[2];

    // Select and negate the captured pair according to the quadrant.
    always_comb begin
        rot_s = sin_ext;
        rot_c = cos_ext;
        case (quad)
            2'd0: begin rot_s = sin_ext;  rot_c = cos_ext;  end
            2'd1: begin rot_s = cos_ext;  rot_c = -sin_ext; end
            2'd2: begin rot_s = -sin_ext; rot_c = -cos_ext; end
            default: begin rot_s = -cos_ext; rot_c = sin_ext; end
        endcase
    end

    // ------------------------------------------------------------------
    // Per-channel magnitude, normalisation and packing.
    // ------------------------------------------------------------------
    logic [MW-1:0] mag_next  [2];
    logic [MW-1:0] norm_next [2];
    logic [7:0]    exp_next  [2];
    logic [31:0]   word_next [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic [5:0]  lead;
            logic [5:0]  shamt;
            logic [23:0] mant;
            logic        guard_bit, sticky_bit, round_up;
            logic [24:0] mant_sum;
            logic [7:0]  exp_fin;
            logic [22:0] frac;
            logic [31:0] word;
            logic        unused_hidden;

            assign mag_next[gi] = rot_reg[gi][MW-1] ? (~rot_reg[gi] + 1'b1) : rot_reg[gi];

            // Priority encoder: the highest set bit wins.
            always_comb begin
                lead = '0;
                for (int b = 0; b < MW; b++) begin
                    if (mag_reg[gi][b]) lead = 6'(b);
                end
            end

            assign shamt         = 6'(MW - 1) - lead;
            assign norm_next[gi] = mag_reg[gi] << shamt;
            assign exp_next[gi]  = 8'd127 + {2'b00, lead} - 8'(FRAC_BITS);

            // 24 kept bits, then guard and sticky for ties-to-even.
            assign mant       = norm_reg[gi][MW-1 -: 24];
            assign guard_bit  = norm_reg[gi][MW-25];
            assign sticky_bit = |norm_reg[gi][MW-26:0];
            assign round_up   = guard_bit & (sticky_bit | mant[0]);
            assign mant_sum   = {1'b0, mant} + {24'd0, round_up};
            assign exp_fin    = mant_sum[24] ? (exp_reg[gi] + 8'd1) : exp_reg[gi];
            assign frac       = mant_sum[24] ? 23'd0 : mant_sum[22:0];
            assign unused_hidden = mant_sum[23];

            // Assemble the final word; zero never carries a sign.
            always_comb begin
                word = {sign_reg[gi], exp_fin, frac};
                if (mag_reg[gi] == '0) begin
                    word = 32'd0;
                end
`ifdef CLAMP_UNIT_EN
                else if (mag_reg[gi] > ONE_MAG) begin
                    word = {sign_reg[gi], 8'd127, 23'd0};
                end
`else
                else if (mag_reg[gi] > ONE_MAG) begin
                    word = {sign_reg[gi], exp_fin, frac};
                end
`endif
            end

            assign word_next[gi] = word;
        end
    endgenerate

    // Next-state logic: fixed one-cycle walk through the stages.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = ROTATE;
            ROTATE:  state_next = MAG;
            MAG:     state_next = NORM;
            NORM:    state_next = PACK;
            PACK:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register and per-stage datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            sin_cap_reg <= '0;
            cos_cap_reg <= '0;
            flips_reg   <= '0;
            sign_reg    <= '0;
            sin_out_reg <= '0;
            cos_out_reg <= '0;
            done_reg    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                rot_reg[i]  <= '0;
                mag_reg[i]  <= '0;
                norm_reg[i] <= '0;
                exp_reg[i]  <= '0;
            end
        end else begin
            state_reg <= state_next;
            done_reg  <= (state_reg == DONE);
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        sin_cap_reg <= sin_in;
                        cos_cap_reg <= cos_in;
                        flips_reg   <= flips;
                    end
                end
                ROTATE: begin
                    rot_reg[0] <= rot_s;
                    rot_reg[1] <= rot_c;
                end
                MAG: begin
                    for (int i = 0; i < 2; i++) begin
                        mag_reg[i]  <= mag_next[i];
                        sign_reg[i] <= rot_reg[i][MW-1];
                    end
                end
                NORM: begin
                    for (int i = 0; i < 2; i++) begin
                        norm_reg[i] <= norm_next[i];
                        exp_reg[i]  <= exp_next[i];
                    end
                end
                PACK: begin
                    sin_out_reg <= word_next[0];
                    cos_out_reg <= word_next[1];
                end
                default: ;
            endcase
        end
    end

    assign sin_out = sin_out_reg;
    assign cos_out = cos_out_reg;
    assign done    = done_reg;

endmodule

// File: tb/tb_cordic_result_packer.sv
// Testbench for cordic_result_packer: directed vector table, reset and busy
// sequences, then random pairs checked against an arithmetic float model.
module tb_cordic_result_packer;

    localparam int W    = 32;
    localparam int FRAC = W - 2;
`ifdef CLAMP_UNIT_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in;
    logic [W-1:0]  sin_in, cos_in;
    logic [2:0]    flips;
    logic [31:0]   sin_out, cos_out;
    logic          done, ready;

    int checks = 0;
    int errors = 0;

    cordic_result_packer #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_in (valid_in),
        .sin_in   (sin_in),
        .cos_in   (cos_in),
        .flips    (flips),
        .sin_out  (sin_out),
        .cos_out  (cos_out),
        .done     (done),
        .ready    (ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] s;
        logic [31:0] c;
        logic [2:0]  f;
        logic [31:0] es;
        logic [31:0] ec;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Reference: signed integer value (units of 2^-FRAC) to single precision.
    function automatic logic [31:0] ref_float(input longint v);
        logic   sgn;
        longint m, q, rem, half;
        int     p, r, e;
        sgn = (v < 0);
        m   = sgn ? -v : v;
        if (m == 0) return 32'd0;
        if (CLAMP && m > (64'sd1 <<< FRAC)) return {sgn, 8'd127, 23'd0};
        p = 0;
        for (int i = 0; i < 63; i++) if (m[i]) p = i;
        if (p > 23) begin
            r    = p - 23;
            q    = m >>> r;
            rem  = m - (q <<< r);
            half = 64'sd1 <<< (r - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (64'sd1 <<< 24)) begin
                q = q >>> 1;
                p = p + 1;
            end
        end else begin
            q = m <<< (23 - p);
        end
        e = 127 + p - FRAC;
        return {sgn, 8'(e), 23'(q)};
    endfunction

    // Reference: undo the folding by repeated quarter turns (s,c) -> (c,-s).
    task automatic ref_rot(input longint s, input longint c, input logic [2:0] f,
                           output longint rs, output longint rc);
        int fi, k;
        longint t;
        fi = int'($signed(f));
        k  = ((-fi) % 4 + 4) % 4;
        rs = s;
        rc = c;
        for (int i = 0; i < k; i++) begin
            t  = rs;
            rs = rc;
            rc = -t;
        end
    endtask

    // Issue one request and follow it to its done pulse.
    task automatic run_conv(input logic [31:0] s, input logic [31:0] c, input logic [2:0] f,
                            output logic [31:0] so, output logic [31:0] co,
                            output int lat, output bit busy_ok, output bit pulse_ok);
        @(negedge clk);
        sin_in   = s;
        cos_in   = c;
        flips    = f;
        valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        lat     = -1;
        busy_ok = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (ready) busy_ok = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
        end
        so = sin_out;
        co = cos_out;
        @(posedge clk);
        #1 pulse_ok = (done == 1'b0) && (ready == 1'b1);
    endtask

    task automatic apply(input string tag, input logic [31:0] s, input logic [31:0] c,
                         input logic [2:0] f, input logic [31:0] es, input logic [31:0] ec);
        logic [31:0] so, co;
        int lat;
        bit busy_ok, pulse_ok;
        chk({tag, " ready_idle"}, {31'd0, ready}, 32'd1);
        run_conv(s, c, f, so, co, lat, busy_ok, pulse_ok);
        $display("%s: sin_in=%08h cos_in=%08h flips=%0d -> sin_out=%08h cos_out=%08h latency=%0d",
                 tag, s, c, $signed(f), so, co, lat);
        chk({tag, " sin_out"}, so, es);
        chk({tag, " cos_out"}, co, ec);
        chk({tag, " latency"}, 32'(lat), 32'd5);
        chk({tag, " ready_busy"}, {31'd0, busy_ok}, 32'd1);
        chk({tag, " done_pulse"}, {31'd0, pulse_ok}, 32'd1);
    endtask

    initial begin
        logic [31:0] so, co, rs32, rc32;
        int lat;
        bit busy_ok, pulse_ok, extra_done;
        longint rs, rc;

        vecs[0]  = '{32'h40000000, 32'h00000000, 3'd0, 32'h3F800000, 32'h00000000};
        vecs[1]  = '{32'h40000000, 32'h00000000, 3'd7, 32'h00000000, 32'hBF800000};
        vecs[2]  = '{32'h20000000, 32'hE0000000, 3'd2, 32'hBF000000, 32'h3F000000};
        vecs[3]  = '{32'h3FFFFFFF, 32'h00000000, 3'd0, 32'h3F800000, 32'h00000000};
        vecs[4]  = '{32'h20000020, 32'h00000000, 3'd0, 32'h3F000000, 32'h00000000};
        vecs[5]  = '{32'h20000060, 32'h00000000, 3'd0, 32'h3F000002, 32'h00000000};
        vecs[6]  = '{32'h00000001, 32'h00000000, 3'd0, 32'h30800000, 32'h00000000};
        vecs[7]  = '{32'h00000000, 32'h00000000, 3'd2, 32'h00000000, 32'h00000000};
        vecs[8]  = '{32'h40000100, 32'h00000000, 3'd0,
                     CLAMP ? 32'h3F800000 : 32'h3F800002, 32'h00000000};
        vecs[9]  = '{32'h10000000, 32'h30000000, 3'd3, 32'h3F400000, 32'hBE800000};
        vecs[10] = '{32'hC0000000, 32'h80000000, 3'd4, 32'hBF800000,
                     CLAMP ? 32'hBF800000 : 32'hC0000000};
        vecs[11] = '{32'h80000000, 32'h00000000, 3'd2,
                     CLAMP ? 32'h3F800000 : 32'h40000000, 32'h00000000};

        rst      = 1'b1;
        valid_in = 1'b0;
        sin_in   = '0;
        cos_in   = '0;
        flips    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset sin_out", sin_out, 32'd0);
        chk("reset cos_out", cos_out, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset ready", {31'd0, ready}, 32'd1);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            apply($sformatf("vec%0d", i), vecs[i].s, vecs[i].c, vecs[i].f, vecs[i].es, vecs[i].ec);
        end

        // Reset while the request sits in NORM (outputs nonzero beforehand).
        apply("pre_reset", 32'h20000000, 32'h10000000, 3'd0, 32'h3F000000, 32'h3E800000);
        @(negedge clk);
        sin_in   = 32'h40000000;
        cos_in   = 32'h40000000;
        flips    = 3'd0;
        valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        $display("midreset: sin_out=%08h cos_out=%08h done=%0d ready=%0d", sin_out, cos_out, done, ready);
        chk("midreset sin_out", sin_out, 32'd0);
        chk("midreset cos_out", cos_out, 32'd0);
        chk("midreset done", {31'd0, done}, 32'd0);
        chk("midreset ready", {31'd0, ready}, 32'd1);
        @(negedge clk) rst = 1'b0;
        apply("post_reset", 32'h20000000, 32'hE0000000, 3'd2, 32'hBF000000, 32'h3F000000);

        // A second request during MAG is dropped; results follow the first.
        @(negedge clk);
        sin_in   = 32'h20000000;
        cos_in   = 32'h10000000;
        flips    = 3'd0;
        valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        @(posedge clk);
        #1;
        sin_in   = 32'h40000000;
        cos_in   = 32'h40000000;
        flips    = 3'd1;
        valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        lat = -1;
        for (int i = 3; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        so = sin_out;
        co = cos_out;
        extra_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done) extra_done = 1'b1;
        end
        $display("busy: sin_out=%08h cos_out=%08h latency=%0d extra_done=%0d", so, co, lat, extra_done);
        chk("busy sin_out", so, 32'h3F000000);
        chk("busy cos_out", co, 32'h3E800000);
        chk("busy latency", 32'(lat), 32'd5);
        chk("busy no_second", {31'd0, extra_done}, 32'd0);

        // Random pairs, some scaled down to reach small exponents.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] s, c;
            logic [2:0] f;
            s = 32'($signed($urandom) >>> $urandom_range(0, 31));
            c = 32'($signed($urandom) >>> $urandom_range(0, 31));
            f = 3'($urandom_range(0, 7));
            ref_rot(longint'($signed(s)), longint'($signed(c)), f, rs, rc);
            rs32 = ref_float(rs);
            rc32 = ref_float(rc);
            apply($sformatf("rand%0d", n), s, c, f, rs32, rc32);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
